// File: rtl/rr_delay_arbiter.sv
// Round-robin arbiter feeding one shared registered 1-cycle delay stage.
// Ports: clk/reset, req_valid/req_ready/req_data per requester, out_valid/out_ready/out_data/out_id, xfer_count.
module rr_delay_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic [CNT_W-1:0]          xfer_count
);

  localparam logic [ID_W:0] NREQ  = NUM_REQ[ID_W:0];
  localparam logic [ID_W:0] ONE_W = {{ID_W{1'b0}}, 1'b1};

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;

  logic                 stage_free;
  logic                 any_valid;
  logic                 xfer;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W-1:0]      off;
  logic                 found;
  logic [ID_W:0]        gsum;
  logic [ID_W-1:0]      grant;
  logic [ID_W:0]        nsum;
  logic [DATA_W-1:0]    win_data;

  assign stage_free = !out_valid_q || out_ready;
  assign any_valid  = |req_valid;
  assign xfer       = !reset && stage_free && any_valid;

  // Rotate so bit 0 is the requester at rr_ptr; first set bit is the offset.
  always_comb begin
    dbl   = {req_valid, req_valid} >> rr_ptr_q;
    rot   = dbl[NUM_REQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        off   = k[ID_W-1:0];
        found = 1'b1;
      end
    end
    gsum = {1'b0, rr_ptr_q} + {1'b0, off};
    if (gsum >= NREQ) gsum = gsum - NREQ;
    grant = gsum[ID_W-1:0];
  end

  always_comb begin
    req_ready = '0;
    win_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == k[ID_W-1:0]) begin
        req_ready[k] = xfer;
        win_data     = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    rr_ptr_d     = rr_ptr_q;
    xfer_count_d = xfer_count_q;
    nsum         = {1'b0, grant} + ONE_W;
    if (nsum == NREQ) nsum = '0;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = win_data;
      out_id_d     = grant;
      rr_ptr_d     = nsum[ID_W-1:0];
      xfer_count_d = xfer_count_q + CNT_W'(1);
    end else if (stage_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      rr_ptr_q     <= '0;
      xfer_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      rr_ptr_q     <= rr_ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_rr_delay_arbiter.sv
// Self-checking bench for rr_delay_arbiter (4 requesters, 8-bit data, 4-bit counter).
// Scoreboard of expected {id,data} words plus per-scenario inline checks.
module tb_rr_delay_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic [CW-1:0]   xfer_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [IW+DW-1:0] sb[$];
  int               m_ptr = 0;
  logic [CW-1:0]    m_cnt = '0;

  rr_delay_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // Reference model sampled mid-cycle, ahead of the next rising edge.
  always @(negedge clk) begin
    logic [N-1:0]     exp_rdy;
    logic [IW+DW-1:0] w;
    int               g;
    bit               free;
    if (reset) begin
      n_cmp++;
      if (req_ready !== '0) begin
        n_err++;
        $display("FAIL mon_reset_ready: got %b want 0000", req_ready);
      end
      sb.delete();
      m_ptr = 0;
      m_cnt = '0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
      free    = !out_valid || out_ready;
      exp_rdy = '0;
      if (free && g >= 0) exp_rdy[g] = 1'b1;
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL mon_ready: got %b want %b", req_ready, exp_rdy);
      end
      n_cmp++;
      if (xfer_count !== m_cnt) begin
        n_err++;
        $display("FAIL mon_count: got %0d want %0d", xfer_count, m_cnt);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_pop: got id %0d data %h want none", out_id, out_data);
        end else begin
          w = sb.pop_front();
          if ({out_id, out_data} !== w) begin
            n_err++;
            $display("FAIL sb_word: got %0d/%h want %0d/%h",
                     out_id, out_data, w[IW+DW-1:DW], w[DW-1:0]);
          end
        end
      end
      if (free && g >= 0) begin
        sb.push_back({2'(g), req_data[g*DW +: DW]});
        m_ptr = (g + 1) % N;
        m_cnt = m_cnt + 4'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      n_cmp++;
      if (req_ready !== '0 || out_valid !== 1'b0 ||
          out_id !== '0 || xfer_count !== '0) begin
        n_err++;
        $display("FAIL reset: rdy %b v %b id %0d cnt %0d want 0",
                 req_ready, out_valid, out_id, xfer_count);
      end
    end
    step();
    reset     = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    req_data[2*DW +: DW] = 8'hA5;
    req_valid = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 ||
        out_id !== 2'd2 || xfer_count !== 4'd1) begin
      n_err++;
      $display("FAIL single_out: got %b/%h/%0d/%0d want 1/a5/2/1",
               out_valid, out_data, out_id, xfer_count);
    end
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'h10 + 8'(i);
    req_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 7) req_valid = '0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_id !== 2'(i % N) ||
          out_data !== 8'h10 + 8'(i % N)) begin
        n_err++;
        $display("FAIL rr_%0d: got %b/%0d/%h want 1/%0d/%h",
                 i, out_valid, out_id, out_data, i % N, 8'h10 + 8'(i % N));
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010;
    out_ready = 1'b0;
    step();
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== '0 || out_valid !== 1'b1 ||
          out_data !== 8'h11 || out_id !== 2'd1) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got %b/%b/%h/%0d want 0000/1/11/1",
                 c, req_ready, out_valid, out_data, out_id);
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL bp_release: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (out_id !== 2'd2 || out_data !== 8'h12) begin
      n_err++;
      $display("FAIL bp_next: got %0d/%h want 2/12", out_id, out_data);
    end
    step();
  endtask

  task automatic test_wrap_skip();
    req_valid = 4'b0011;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL wrap_g0: got %b want 0001", req_ready);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010 || out_id !== 2'd0) begin
      n_err++;
      $display("FAIL wrap_g1: got %b/%0d want 0010/0", req_ready, out_id);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (out_id !== 2'd1 || out_data !== 8'h11) begin
      n_err++;
      $display("FAIL wrap_out1: got %0d/%h want 1/11", out_id, out_data);
    end
    step();
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 17; c++) begin
      step();
      if (c == 16) req_valid = '0;
    end
    @(negedge clk);
    n_cmp++;
    if (xfer_count !== 4'd1) begin
      n_err++;
      $display("FAIL count_wrap: got %0d want 1", xfer_count);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0001;
    out_ready = 1'b0;
    step();
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_held: got %b want 1", out_valid);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_cleared: got %b want 0", out_valid);
    end
    step();
    reset     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_ptr: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 8'h10) begin
      n_err++;
      $display("FAIL mid_out: got %b/%0d/%h want 1/0/10",
               out_valid, out_id, out_data);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_idle: got %b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid();
    step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
